seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (legal range 2..2^20).
REQ-002 The block SHALL have parameter BLANK_LEADING, default 1, where 1 blanks leading zeros.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single system clock; all logic rises on its posedge.
REQ-004 The block SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port en_i, input, 1 bit, display enable.
REQ-006 The block SHALL have port num_i, input, 13 bits, binary value to show (0..8191).
REQ-007 The block SHALL have port load_i, input, 1 bit, single-cycle capture strobe for num_i.
REQ-008 The block SHALL have port anode_o, output, 4 bits, active-low digit enables; bit 0 = ones digit.
REQ-009 The block SHALL have port seg_o, output, 7 bits, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port updated_o, output, 1 bit, one-cycle pulse when a new value becomes visible.

Function
REQ-011 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the slot tick.
REQ-012 On each slot tick the digit index SHALL advance 0->1->2->3->0, updating anode_o and seg_o on the same edge.
REQ-013 With en_i=1, anode_o SHALL be all ones except bit[index], which SHALL be 0.
REQ-014 With en_i=0, anode_o SHALL be 4'b1111; the counter and index SHALL keep running.
REQ-015 When load_i=1 at edge N, num_i SHALL be captured into a hold register at edge N.
REQ-016 At edge N+1, the four BCD digits of the hold value SHALL be registered into a pending set, and a pending flag SHALL be set.
REQ-017 A pending set SHALL be copied to the display set only on the slot tick where the index wraps 3->0, so frames never tear.
REQ-018 updated_o SHALL pulse high for exactly the cycle following that copy.
REQ-019 A load arriving while a set is pending SHALL overwrite it; only the newest value is displayed, with one updated_o pulse.
REQ-020 A load coinciding with the 3->0 tick SHALL NOT be applied in that frame; it SHALL be applied at the next frame boundary.
REQ-021 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Digit codes 10..15 SHALL produce blank (1111111).
REQ-022 With BLANK_LEADING=1, a displayed digit SHALL be blanked (seg_o=1111111) when it and all higher digits are 0.
REQ-023 The ones digit SHALL never be blanked, so value 0 shows "0".

Reset
REQ-024 While rst_i=1 at a posedge, the following SHALL be cleared: counter=0, index=0, hold=0, pending=0, display set=0, anode_o=4'b1111, seg_o=7'b1111111, updated_o=0.
REQ-025 The first slot tick SHALL occur REFRESH_DIV cycles after rst_i deasserts; a reset mid-frame SHALL discard any pending value.

Structure
REQ-026 Package seven_seg_pkg SHALL hold the segment-code constants, the blank code and NUM_DIGITS=4.
REQ-027 Binary-to-BCD conversion SHALL be done by one instance of the existing combinational converter bcd, fed from the hold register.
REQ-028 Segment decode SHALL be a function in seven_seg_pkg; no additional sub-modules.

Verification (REFRESH_DIV=4)
REQ-029 Reset, then run 16 cycles -> anode_o sequence 1110,1101,1011,0111 (4 cycles each); all digits blank except ones, which shows "0".
REQ-030 load num_i=1234 mid-frame -> digits stay 0 until the 3->0 tick; then ones=0011001, tens=0110000, hundreds=0100100, thousands=1111001, and updated_o pulses once.
REQ-031 load 8191 then load 42 before the frame boundary -> only "42" appears; thousands and hundreds are blank; exactly one updated_o pulse.
REQ-032 load 7 on the exact 3->0 tick cycle -> the old value persists a full frame; "7" appears at the following boundary.
REQ-033 en_i=0 for 10 cycles -> anode_o=1111 throughout; the index continues, and on re-enable the anode matches the expected rotation.
REQ-034 load 500, then assert rst_i mid-frame before the boundary -> reset values appear next cycle, and the display shows "0", not 500.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment codes, blank code, digit count and the segment decoder
package seven_seg_pkg;
   localparam int NUM_DIGITS = 4;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/bcd.sv
// bcd: combinational 13-bit binary to four-digit BCD converter (shift-add-3)
module bcd
   import seven_seg_pkg::*;
(
   input  logic [12:0]              bin_i,
   output logic [4*NUM_DIGITS-1:0]  bcd_o
);
   logic [4*NUM_DIGITS-1:0] v;

   // Double dabble: correct each digit above 4 before shifting in the next bit
   always_comb begin
      v = '0;
      for (int i = 12; i >= 0; i--) begin
         for (int d = 0; d < NUM_DIGITS; d++)
            if (v[4*d +: 4] > 4'd4) v[4*d +: 4] = v[4*d +: 4] + 4'd3;
         v = {v[4*NUM_DIGITS-2:0], bin_i[i]};
      end
      bcd_o = v;
   end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed 4-digit seven-segment driver with tear-free frame updates
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [12:0] num_i,
   input  logic        load_i,
   output logic [3:0]  anode_o,
   output logic [6:0]  seg_o,
   output logic        updated_o
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int DW = 4 * NUM_DIGITS;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [12:0]   hold_q;
   logic          load_q, pend_flag_q, pend_flag_d, upd_q;
   logic [DW-1:0] bcd_w, pend_q, disp_q, disp_d;
   logic [3:0]    anode_q, anode_d, zero_w, lead_w, digit;
   logic [6:0]    seg_q, seg_d;
   logic          tick, wrap, blank;

   bcd u_bcd (
      .bin_i (hold_q),
      .bcd_o (bcd_w)
   );

   // Next state: slot counter, scan index, frame-boundary copy and the outputs for the new slot
   always_comb begin
      tick        = cnt_q == CW'(REFRESH_DIV - 1);
      wrap        = tick && idx_q == 2'd3;
      cnt_d       = tick ? '0 : cnt_q + CW'(1);
      idx_d       = tick ? idx_q + 2'd1 : idx_q;
      disp_d      = (wrap && pend_flag_q) ? pend_q : disp_q;
      pend_flag_d = load_q ? 1'b1 : (wrap ? 1'b0 : pend_flag_q);
      for (int i = 0; i < NUM_DIGITS; i++) zero_w[i] = disp_d[4*i +: 4] == 4'd0;
      lead_w      = {zero_w[3], &zero_w[3:2], &zero_w[3:1], 1'b0};
      digit       = disp_d[{idx_d, 2'b00} +: 4];
      blank       = BLANK_LEADING && lead_w[idx_d];
      seg_d       = blank ? SEG_BLANK : seg_decode(digit);
      anode_d     = en_i ? ~(4'b0001 << idx_d) : 4'b1111;
   end

   // State and registered outputs; a load lands in hold, then its BCD lands in pending a cycle later
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         hold_q      <= '0;
         load_q      <= 1'b0;
         pend_q      <= '0;
         pend_flag_q <= 1'b0;
         disp_q      <= '0;
         anode_q     <= 4'b1111;
         seg_q       <= SEG_BLANK;
         upd_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         if (load_i) hold_q <= num_i;
         load_q      <= load_i;
         if (load_q) pend_q <= bcd_w;
         pend_flag_q <= pend_flag_d;
         disp_q      <= disp_d;
         anode_q     <= anode_d;
         seg_q       <= seg_d;
         upd_q       <= wrap && pend_flag_q;
      end
   end

   assign anode_o   = anode_q;
   assign seg_o     = seg_q;
   assign updated_o = upd_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed checks of scanning, frame-aligned loads, enable and reset
module tb_seven_seg_scan_ctrl;
   localparam logic [7:0] S0 = 8'b01000000;
   localparam logic [7:0] S1 = 8'b01111001;
   localparam logic [7:0] S2 = 8'b00100100;
   localparam logic [7:0] S3 = 8'b00110000;
   localparam logic [7:0] S4 = 8'b00011001;
   localparam logic [7:0] S7 = 8'b01111000;
   localparam logic [7:0] BL = 8'b01111111;

   logic        clk = 1'b0, rst = 1'b1, en = 1'b1, load = 1'b0;
   logic [12:0] num = '0;
   logic [3:0]  anode, ea;
   logic [6:0]  seg;
   logic        upd;
   logic [7:0]  an8, seg8, up8;
   int          k = 0, n_chk = 0, n_fail = 0, upd_cnt = 0, base = 0, idx;

   seven_seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .num_i     (num),
      .load_i    (load),
      .anode_o   (anode),
      .seg_o     (seg),
      .updated_o (upd)
   );

   assign an8  = {4'b0, anode};
   assign seg8 = {1'b0, seg};
   assign up8  = {7'b0, upd};

   always #5 clk = ~clk;

   always @(posedge clk) if (upd === 1'b1) upd_cnt++;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int t);
      while (k < t) step();
   endtask

   initial begin
      step();
      step();
      chk("rst_anode", an8, 8'h0F);
      chk("rst_seg", seg8, BL);
      chk("rst_upd", up8, 8'h00);
      rst = 1'b0;
      k = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         idx = (i / 4) % 4;
         ea = ~(4'b0001 << idx);
         chk("scan_anode", an8, {4'b0, ea});
         chk("scan_seg", seg8, idx == 0 ? S0 : BL);
      end
      num = 13'd1234; load = 1'b1; step(); load = 1'b0;
      chk("pre_upd", up8, 8'h00);
      chk("pre_ones", seg8, S0);
      run_to(28);
      base = upd_cnt;
      chk("pre_thou", seg8, BL);
      run_to(31);
      chk("pre_wrap_upd", up8, 8'h00);
      run_to(32);
      chk("1234_upd", up8, 8'h01);
      chk("1234_ones", seg8, S4);
      chk("1234_anode", an8, 8'h0E);
      run_to(33);
      chk("1234_upd_low", up8, 8'h00);
      run_to(36);
      chk("1234_tens", seg8, S3);
      run_to(40);
      chk("1234_hund", seg8, S2);
      run_to(44);
      chk("1234_thou", seg8, S1);
      chk("1234_pulses", 8'(upd_cnt - base), 8'd1);
      run_to(48);
      base = upd_cnt;
      num = 13'd8191; load = 1'b1; step(); load = 1'b0;
      run_to(51);
      num = 13'd42; load = 1'b1; step(); load = 1'b0;
      run_to(60);
      chk("ovr_old_thou", seg8, S1);
      run_to(64);
      chk("42_upd", up8, 8'h01);
      chk("42_ones", seg8, S2);
      run_to(68);
      chk("42_tens", seg8, S4);
      run_to(72);
      chk("42_hund", seg8, BL);
      run_to(76);
      chk("42_thou", seg8, BL);
      run_to(79);
      num = 13'd7; load = 1'b1; step(); load = 1'b0;
      chk("tick_load_upd", up8, 8'h00);
      chk("tick_load_ones", seg8, S2);
      chk("42_pulses", 8'(upd_cnt - base), 8'd1);
      run_to(84);
      chk("tick_load_tens", seg8, S4);
      run_to(95);
      chk("7_pre_upd", up8, 8'h00);
      run_to(96);
      chk("7_upd", up8, 8'h01);
      chk("7_ones", seg8, S7);
      run_to(100);
      chk("7_tens", seg8, BL);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("dis_anode", an8, 8'h0F);
      end
      en = 1'b1;
      step();
      chk("reen_anode", an8, 8'h07);
      chk("reen_seg", seg8, BL);
      run_to(112);
      num = 13'd500; load = 1'b1; step(); load = 1'b0;
      run_to(116);
      rst = 1'b1;
      step();
      chk("mid_rst_anode", an8, 8'h0F);
      chk("mid_rst_seg", seg8, BL);
      chk("mid_rst_upd", up8, 8'h00);
      rst = 1'b0;
      k = 0;
      base = upd_cnt;
      step();
      chk("post_rst_anode", an8, 8'h0E);
      chk("post_rst_ones", seg8, S0);
      run_to(16);
      chk("post_rst_wrap_upd", up8, 8'h00);
      chk("post_rst_wrap_ones", seg8, S0);
      run_to(20);
      chk("post_rst_tens", seg8, BL);
      run_to(24);
      chk("post_rst_hund", seg8, BL);
      chk("post_rst_pulses", 8'(upd_cnt - base), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
